// File: rtl/mpmc11_rd_req_if.sv
// Client, controller and read-ack signals of one mpmc11 port read-request path.
// The slave modport is the request issuer; master is the client/controller side.
interface mpmc11_rd_req_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int ADR_W = 32
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             cpu_req;
    logic [TAG_W-1:0] cpu_tag;
    logic [ADR_W-1:0] cpu_adr;
    logic             cpu_rdy;
    logic             mc_req;
    logic [ADR_W-1:0] mc_adr;
    logic             mc_accept;
    logic             port_ack;
    logic             resp_vld;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_err;
    logic             spur_ack;
    logic [CNT_W-1:0] outstanding;

    modport master (
        output cpu_req, cpu_tag, cpu_adr, mc_accept, port_ack,
        input  cpu_rdy, mc_req, mc_adr, resp_vld, resp_tag, resp_err,
               spur_ack, outstanding
    );

    modport slave (
        input  cpu_req, cpu_tag, cpu_adr, mc_accept, port_ack,
        output cpu_rdy, mc_req, mc_adr, resp_vld, resp_tag, resp_err,
               spur_ack, outstanding
    );
endinterface

// File: rtl/mpmc11_rd_req.sv
// mpmc11 port read-request issuer: issues client reads to the controller, keeps
// issued tags in order, retires them on read-ack or on watchdog timeout.
module mpmc11_rd_req #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int ADR_W = 32,
    parameter int TMO   = 1023
) (
    input logic            clk,
    input logic            rst,
    mpmc11_rd_req_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int WD_W  = $clog2(TMO + 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    state_t           state_r;
    logic             mc_req_r;
    logic [ADR_W-1:0] mc_adr_r;
    logic [TAG_W-1:0] hold_tag_r;

    logic [TAG_W-1:0] fifo_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WD_W-1:0]  wdog_r;

    logic             resp_vld_r;
    logic [TAG_W-1:0] resp_tag_r;
    logic             resp_err_r;
    logic             spur_r;

    logic cpu_rdy_s;
    logic take_s;
    logic push_s;
    logic has_out_s;
    logic ack_pop_s;
    logic tmo_pop_s;
    logic pop_s;
    logic spur_s;

    // Handshake and retire decode; an ack in the limit cycle wins over the timeout.
    always_comb begin
        has_out_s = (cnt_r != CNT_W'(0));
        cpu_rdy_s = (state_r == ST_IDLE) && (cnt_r < CNT_W'(DEPTH));
        take_s    = cpu_rdy_s && bus.cpu_req;
        push_s    = (state_r == ST_ISSUE) && bus.mc_accept;
        ack_pop_s = bus.port_ack && has_out_s;
        spur_s    = bus.port_ack && !has_out_s;
        tmo_pop_s = !bus.port_ack && has_out_s && (wdog_r == WD_W'(TMO));
        pop_s     = ack_pop_s || tmo_pop_s;
    end

    // Command FSM: latch the command, hold mc_req and mc_adr until accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            mc_req_r   <= 1'b0;
            mc_adr_r   <= {ADR_W{1'b0}};
            hold_tag_r <= {TAG_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (take_s) begin
                        mc_adr_r   <= bus.cpu_adr;
                        hold_tag_r <= bus.cpu_tag;
                        mc_req_r   <= 1'b1;
                        state_r    <= ST_ISSUE;
                    end else begin
                        mc_req_r   <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (bus.mc_accept) begin
                        mc_req_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else begin
                        mc_req_r <= 1'b1;
                    end
                end
                default: begin
                    mc_req_r <= 1'b0;
                    state_r  <= ST_IDLE;
                end
            endcase
        end
    end

    // Tag FIFO, outstanding count, watchdog and registered response strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_r[i] <= {TAG_W{1'b0}};
            end
            wr_ptr_r   <= {PTR_W{1'b0}};
            rd_ptr_r   <= {PTR_W{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            wdog_r     <= {WD_W{1'b0}};
            resp_vld_r <= 1'b0;
            resp_tag_r <= {TAG_W{1'b0}};
            resp_err_r <= 1'b0;
            spur_r     <= 1'b0;
        end else begin
            if (push_s) begin
                fifo_r[wr_ptr_r] <= hold_tag_r;
                wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
                resp_tag_r <= fifo_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   cnt_r <= cnt_r + CNT_W'(1);
                2'b01:   cnt_r <= cnt_r - CNT_W'(1);
                default: cnt_r <= cnt_r;
            endcase
            // Counter restarts whenever the head changes or nothing is pending.
            if (!has_out_s || pop_s) begin
                wdog_r <= {WD_W{1'b0}};
            end else begin
                wdog_r <= wdog_r + WD_W'(1);
            end
            resp_vld_r <= pop_s;
            resp_err_r <= tmo_pop_s;
            spur_r     <= spur_s;
        end
    end

    assign bus.cpu_rdy     = cpu_rdy_s;
    assign bus.mc_req      = mc_req_r;
    assign bus.mc_adr      = mc_adr_r;
    assign bus.resp_vld    = resp_vld_r;
    assign bus.resp_tag    = resp_tag_r;
    assign bus.resp_err    = resp_err_r;
    assign bus.spur_ack    = spur_r;
    assign bus.outstanding = cnt_r;
endmodule

// File: tb/tb_mpmc11_rd_req.sv
// Self-checking bench for mpmc11_rd_req: a behavioural port model fills a
// response scoreboard; directed sequences cover the read, fill, timeout and reset cases.
module tb_mpmc11_rd_req;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int ADR_W = 32;
    localparam int TMO   = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mpmc11_rd_req_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADR_W(ADR_W)) bus ();

    mpmc11_rd_req #(.DEPTH(DEPTH), .TAG_W(TAG_W), .ADR_W(ADR_W), .TMO(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model state
    logic [TAG_W-1:0] mq [$];
    logic [TAG_W:0]   sb [$];
    logic [TAG_W:0]   sb_item;
    bit               m_issue = 1'b0;
    logic [TAG_W-1:0] m_tag   = '0;
    logic [ADR_W-1:0] m_adr   = '0;
    int               m_wd    = 0;
    int               m_sz    = 0;
    bit               m_ack   = 1'b0;
    bit               m_tmo   = 1'b0;
    bit               e_vld   = 1'b0;
    bit               e_spur  = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                mq.delete();
                sb.delete();
                m_issue = 1'b0;
                m_tag   = '0;
                m_adr   = '0;
                m_wd    = 0;
                e_vld   = 1'b0;
                e_spur  = 1'b0;
            end else begin
                m_sz   = mq.size();
                m_ack  = bus.port_ack && (m_sz > 0);
                m_tmo  = !bus.port_ack && (m_sz > 0) && (m_wd == TMO);
                e_vld  = m_ack || m_tmo;
                e_spur = bus.port_ack && (m_sz == 0);
                if (e_vld) begin
                    sb.push_back({mq[0], m_tmo});
                    void'(mq.pop_front());
                end
                m_wd = ((m_sz == 0) || e_vld) ? 0 : m_wd + 1;
                if (!m_issue) begin
                    if (bus.cpu_req && (m_sz < DEPTH)) begin
                        m_issue = 1'b1;
                        m_tag   = bus.cpu_tag;
                        m_adr   = bus.cpu_adr;
                    end
                end else if (bus.mc_accept) begin
                    m_issue = 1'b0;
                    mq.push_back(m_tag);
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check_val("mc_req", 64'(bus.mc_req), 64'(m_issue));
                check_val("outstanding", 64'(bus.outstanding), 64'(mq.size()));
                check_val("cpu_rdy", 64'(bus.cpu_rdy), 64'(!m_issue && (mq.size() < DEPTH)));
                check_val("resp_vld", 64'(bus.resp_vld), 64'(e_vld));
                check_val("spur_ack", 64'(bus.spur_ack), 64'(e_spur));
                if (m_issue) check_val("mc_adr", 64'(bus.mc_adr), 64'(m_adr));
                if (bus.resp_vld && e_vld && (sb.size() > 0)) begin
                    sb_item = sb.pop_front();
                    check_val("sb_tag", 64'(bus.resp_tag), 64'(sb_item[TAG_W:1]));
                    check_val("sb_err", 64'(bus.resp_err), 64'(sb_item[0]));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [TAG_W-1:0] tag, input logic [ADR_W-1:0] adr, input int acc_dly);
        int guard;
        guard       = 0;
        bus.cpu_req = 1'b1;
        bus.cpu_tag = tag;
        bus.cpu_adr = adr;
        while (!bus.cpu_rdy && (guard < 50)) begin
            tick();
            guard++;
        end
        check_val("rdy_wait_expired", 64'(guard >= 50), 64'(0));
        tick();
        bus.cpu_req = 1'b0;
        repeat (acc_dly) tick();
        bus.mc_accept = 1'b1;
        tick();
        bus.mc_accept = 1'b0;
    endtask

    task automatic ack();
        bus.port_ack = 1'b1;
        tick();
        bus.port_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got expired expected finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int c;
        bus.cpu_req   = 1'b0;
        bus.cpu_tag   = '0;
        bus.cpu_adr   = '0;
        bus.mc_accept = 1'b0;
        bus.port_ack  = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_mc_req", 64'(bus.mc_req), 64'(0));
        check_val("rst_outstanding", 64'(bus.outstanding), 64'(0));
        check_val("rst_resp_vld", 64'(bus.resp_vld), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        tick();
        check_val("rst_cpu_rdy", 64'(bus.cpu_rdy), 64'(1));
        check_val("rst_mc_adr", 64'(bus.mc_adr), 64'(0));

        // Single read
        send(4'h3, 32'h0000_1000, 2);
        check_val("single_out1", 64'(bus.outstanding), 64'(1));
        repeat (4) tick();
        ack();
        check_val("single_vld", 64'(bus.resp_vld), 64'(1));
        check_val("single_tag", 64'(bus.resp_tag), 64'(3));
        check_val("single_err", 64'(bus.resp_err), 64'(0));
        check_val("single_out0", 64'(bus.outstanding), 64'(0));
        tick();
        check_val("single_vld_drop", 64'(bus.resp_vld), 64'(0));

        // Fill to DEPTH, fifth command waits for the first ack
        for (int t = 1; t <= 4; t++) send(TAG_W'(t), 32'h0000_2000 + 32'(t * 16), 0);
        check_val("fill_full", 64'(bus.outstanding), 64'(4));
        check_val("fill_rdy_low", 64'(bus.cpu_rdy), 64'(0));
        bus.cpu_req = 1'b1;
        bus.cpu_tag = 4'h5;
        bus.cpu_adr = 32'h0000_2050;
        repeat (2) tick();
        check_val("fill_rdy_held", 64'(bus.cpu_rdy), 64'(0));
        ack();
        check_val("fill_first_tag", 64'(bus.resp_tag), 64'(1));
        check_val("fill_rdy_back", 64'(bus.cpu_rdy), 64'(1));
        tick();
        bus.cpu_req = 1'b0;
        check_val("fill_mc_req5", 64'(bus.mc_req), 64'(1));
        bus.mc_accept = 1'b1;
        tick();
        bus.mc_accept = 1'b0;
        check_val("fill_out4", 64'(bus.outstanding), 64'(4));
        bus.port_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("fill_b2b_vld", 64'(bus.resp_vld), 64'(1));
            check_val("fill_b2b_tag", 64'(bus.resp_tag), 64'(i + 2));
        end
        bus.port_ack = 1'b0;
        check_val("fill_drained", 64'(bus.outstanding), 64'(0));

        // Simultaneous push and pop
        send(4'h7, 32'h0000_3000, 0);
        send(4'h8, 32'h0000_3010, 0);
        bus.cpu_req = 1'b1;
        bus.cpu_tag = 4'h9;
        bus.cpu_adr = 32'h0000_3020;
        tick();
        bus.cpu_req   = 1'b0;
        bus.mc_accept = 1'b1;
        bus.port_ack  = 1'b1;
        tick();
        bus.mc_accept = 1'b0;
        bus.port_ack  = 1'b0;
        check_val("pp_out", 64'(bus.outstanding), 64'(2));
        check_val("pp_tag", 64'(bus.resp_tag), 64'(7));
        ack();
        check_val("pp_tag2", 64'(bus.resp_tag), 64'(8));
        ack();
        check_val("pp_tag3", 64'(bus.resp_tag), 64'(9));

        // Spurious ack
        tick();
        ack();
        check_val("spur_pulse", 64'(bus.spur_ack), 64'(1));
        check_val("spur_no_vld", 64'(bus.resp_vld), 64'(0));
        check_val("spur_out", 64'(bus.outstanding), 64'(0));
        tick();
        check_val("spur_once", 64'(bus.spur_ack), 64'(0));

        // Timeout retire
        send(4'hA, 32'h0000_4000, 0);
        c = 0;
        while (!bus.resp_vld && (c < 40)) begin
            tick();
            c++;
        end
        check_val("tmo_latency", 64'(c), 64'(TMO + 1));
        check_val("tmo_err", 64'(bus.resp_err), 64'(1));
        check_val("tmo_tag", 64'(bus.resp_tag), 64'(4'hA));
        check_val("tmo_out", 64'(bus.outstanding), 64'(0));

        // Ack in the limit cycle suppresses the timeout
        tick();
        send(4'hB, 32'h0000_4010, 0);
        repeat (TMO) tick();
        ack();
        check_val("lim_vld", 64'(bus.resp_vld), 64'(1));
        check_val("lim_err", 64'(bus.resp_err), 64'(0));
        check_val("lim_tag", 64'(bus.resp_tag), 64'(4'hB));
        tick();
        check_val("lim_no_second", 64'(bus.resp_vld), 64'(0));

        // Asynchronous reset while in ISSUE with three outstanding
        send(4'h1, 32'h0000_5000, 0);
        send(4'h2, 32'h0000_5010, 0);
        send(4'h3, 32'h0000_5020, 0);
        bus.cpu_req = 1'b1;
        bus.cpu_tag = 4'h4;
        bus.cpu_adr = 32'h0000_5030;
        tick();
        bus.cpu_req = 1'b0;
        check_val("ar_pre_out", 64'(bus.outstanding), 64'(3));
        check_val("ar_pre_req", 64'(bus.mc_req), 64'(1));
        #2;
        rst = 1'b0;
        #1;
        check_val("ar_mc_req", 64'(bus.mc_req), 64'(0));
        check_val("ar_mc_adr", 64'(bus.mc_adr), 64'(0));
        check_val("ar_out", 64'(bus.outstanding), 64'(0));
        check_val("ar_resp_vld", 64'(bus.resp_vld), 64'(0));
        check_val("ar_resp_tag", 64'(bus.resp_tag), 64'(0));
        check_val("ar_resp_err", 64'(bus.resp_err), 64'(0));
        check_val("ar_spur", 64'(bus.spur_ack), 64'(0));
        check_val("ar_cpu_rdy", 64'(bus.cpu_rdy), 64'(1));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        tick();
        send(4'h5, 32'h0000_6000, 1);
        repeat (3) tick();
        ack();
        check_val("ar_fresh_vld", 64'(bus.resp_vld), 64'(1));
        check_val("ar_fresh_tag", 64'(bus.resp_tag), 64'(5));
        check_val("ar_fresh_err", 64'(bus.resp_err), 64'(0));
        repeat (2) tick();
        check_val("sb_empty", 64'(sb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mpmc11_rd_req.md
# mpmc11_rd_req

Port-side read request issuer and acknowledge tracker for an mpmc11 memory port; it is the initiator end of the read-ack path. It accepts read commands from a port client, presents them to the controller request interface, and holds issued tags in order. It matches each single-cycle read-ack pulse, already synchronized into the port clock domain, to the oldest outstanding tag. A watchdog retires requests whose ack never arrives.

## Interface
- DEPTH, 4, maximum outstanding reads; power of two, 2..16
- TAG_W, 4, client tag width
- ADR_W, 32, address width
- TMO, 1023, watchdog limit in clk cycles; minimum 2
- clk  in  1  port clock; all logic is on its rising edge
- rst  in  1  reset, asynchronous, active-low
- cpu_req  in  1  client read command valid
- cpu_tag  in  TAG_W  client tag
- cpu_adr  in  ADR_W  read address
- cpu_rdy  out  1  command accepted when cpu_req && cpu_rdy
- mc_req  out  1  request to controller; held until accepted
- mc_adr  out  ADR_W  latched address
- mc_accept  in  1  one-cycle pulse; controller took the request
- port_ack  in  1  one-cycle read-ack pulse from the ack synchronizer
- resp_vld  out  1  one-cycle response strobe
- resp_tag  out  TAG_W  tag of the retired request
- resp_err  out  1  qualifies resp_vld; 1 means retired by timeout
- spur_ack  out  1  one-cycle pulse; port_ack arrived with nothing outstanding
- outstanding  out  $clog2(DEPTH)+1  count of issued, unretired reads

## Operation
- The FSM has two states. IDLE is the reset state; in IDLE, cpu_rdy = (outstanding < DEPTH). ISSUE: mc_req = 1 and cpu_rdy = 0.
- IDLE and cpu_req && cpu_rdy: latch cpu_adr into mc_adr and cpu_tag into a holding register, then go to ISSUE.
- ISSUE and mc_accept: push the held tag into the tag FIFO, increment outstanding, go to IDLE. mc_adr stays stable for the whole of ISSUE.
- Tag FIFO: DEPTH entries with wrapping read and write pointers. It is full when outstanding == DEPTH, and pushes never occur while full.
- port_ack with outstanding > 0: pop the head, output resp_tag = head tag with resp_err = 0, and decrement outstanding.
- port_ack with outstanding == 0: no state change; pulse spur_ack.
- A push and a pop in the same cycle leave outstanding unchanged. Pointers advance independently. If the FIFO is empty, the popping ack is spurious and the push completes normally.
- Watchdog counter:
  - It is cleared when outstanding == 0, and on every pop.
  - Otherwise it increments each cycle.
  - When it reaches TMO, the block pops the head with resp_err = 1 and clears the counter.
  - If port_ack arrives in that same cycle, the ack retires the head normally and the timeout is suppressed.
- An ack arriving after its request timed out is matched to the next head. Software treats any resp_err as fatal for the port.
- Reset mid-operation clears the FIFO, pointers, counter and FSM immediately. Outstanding controller transactions are abandoned.

## Timing
- Reset values: cpu_rdy = 1 (after reset deassert, while outstanding = 0), mc_req = 0, mc_adr = 0, resp_vld = 0, resp_tag = 0, resp_err = 0, spur_ack = 0, outstanding = 0.
- All outputs are registered except cpu_rdy, which is decoded from the state and the registered count.
- Command accepted at edge n: mc_req is high from n+1.
- mc_accept sampled at edge m: mc_req is low and outstanding is updated at m+1. cpu_rdy can be high at m+1, so the minimum command interval is 2 cycles.
- port_ack sampled at edge k: resp_vld, resp_tag and resp_err are valid during cycle k+1 and outstanding is updated at k+1. Back-to-back acks give back-to-back responses.
- The timeout fires TMO cycles after the counter last cleared. The response appears one cycle after the counter reaches TMO.
- spur_ack is high during cycle k+1.

## Test plan
- Single read: tag 0x3, adr 0x1000; mc_accept 2 cycles after mc_req rises; port_ack 5 cycles later -> resp_vld for one cycle with resp_tag = 0x3 and resp_err = 0; outstanding goes 0, 1, 0.
- Fill: with DEPTH = 4, issue tags 1..5 back-to-back with immediate accepts -> cpu_rdy drops after the 4th; 4 acks return tags 1,2,3,4 in order; tag 5 is issued after the first ack.
- Simultaneous push and pop: mc_accept and port_ack in the same cycle with outstanding = 2 -> outstanding stays 2 and the oldest tag is returned.
- Spurious ack: port_ack with outstanding = 0 -> spur_ack pulses once, no resp_vld, outstanding stays 0.
- Timeout: with TMO = 16, one read accepted and no ack -> after 16 cycles resp_vld = 1, resp_err = 1, the tag is returned and outstanding = 0. Repeat with port_ack in the limit cycle -> resp_err = 0.
- Async reset: assert rst low while in ISSUE with outstanding = 3 -> all outputs go to their reset values without a clock edge; after release, a fresh read completes normally.
